// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmit and receive paths:
//   tx_state_e   - serializer states (IDLE, START, DATA, STOP)
//   BitsPerFrame - line bits in one 8N1 frame (start + 8 data + stop)
//   calc_div()   - clocks per line bit, rounded to nearest
// No ports.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    localparam int BitsPerFrame = 10;

    // Rounded rather than truncated so the achieved baud rate is as close
    // to nominal as the integer divider allows.
    function automatic int calc_div(input int clk_freq, input int baud_rate);
        return (clk_freq + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// 8N1 single-byte serializer with its own baud counter.
//
// state | meaning
// IDLE  | line idle high, waiting for a byte
// START | start bit (low) for Div cycles
// DATA  | 8 data bits LSB first, Div cycles each
// STOP  | stop bit (high) for Div cycles
//
// Ports:
//   clk_i   in   system clock
//   rst_i   in   synchronous reset, active-high
//   data_i  in   [7:0] byte to send
//   valid_i in   data_i is valid
//   ready_o out  byte accepted this cycle if valid_i is high
//   idle_o  out  serializer is in IDLE
//   tx_o    out  serial line, registered, idle high
// -----------------------------------------------------------------------------
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int Div = 280
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       idle_o,
    output logic       tx_o
);

    localparam int              CntW    = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);

    tx_state_e       r_state;
    logic [CntW-1:0] r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_tx;

    logic            w_baud_end;
    logic            w_accept;

    assign w_baud_end = (r_baud == CntLast);
    // Also ready in the final stop-bit cycle so the next frame's start bit
    // follows with no idle gap.
    assign ready_o    = (r_state == TX_IDLE) || ((r_state == TX_STOP) && w_baud_end);
    assign idle_o     = (r_state == TX_IDLE);
    assign w_accept   = valid_i && ready_o;
    assign tx_o       = r_tx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= TX_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else if (w_accept) begin
            r_state <= TX_START;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= data_i;
            r_tx    <= 1'b0;
        end else if (r_state != TX_IDLE) begin
            if (w_baud_end) begin
                r_baud <= '0;
                unique case (r_state)
                    TX_START: begin
                        r_state <= TX_DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                    TX_DATA: begin
                        if (r_bit == 3'd7) begin
                            r_state <= TX_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end
                    default: begin
                        r_state <= TX_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end else begin
                r_baud <= r_baud + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// -----------------------------------------------------------------------------
// uart_word_tx
// Word sequencer: accepts a 32-bit word over valid/ready and sends it as
// BytesPerWord back-to-back 8N1 frames, least-significant byte first.
//
// Build option: UART_WORD_TX_CKSUM_EN - when defined, one extra frame holding
// the XOR of the word's bytes follows the last data byte.
//
// Ports:
//   clk_i   in   system clock
//   rst_i   in   synchronous reset, active-high
//   data_i  in   [31:0] word to transmit
//   valid_i in   data_i is valid
//   ready_o out  word accepted this cycle if valid_i is high (IDLE only)
//   busy_o  out  frame sequence in progress (= !ready_o)
//   tx_o    out  UART serial line, idle high
// -----------------------------------------------------------------------------
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int ClkFreq      = 32250000,
    parameter int BaudRate     = 115200,
    parameter int BytesPerWord = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        tx_o
);

    localparam int Div = calc_div(ClkFreq, BaudRate);
`ifdef UART_WORD_TX_CKSUM_EN
    localparam int NFrames = BytesPerWord + 1;
`else
    localparam int NFrames = BytesPerWord;
`endif
    localparam int LeftW  = $clog2(NFrames + 1);
    localparam int ShiftW = 8 * NFrames;

    logic [ShiftW-1:0] w_frame;
    logic [ShiftW-1:0] r_shift;
    logic [LeftW-1:0]  r_left;
    logic              w_ready;
    logic              w_idle;
    logic              w_byte_ready;
    logic              w_byte_valid;
    logic [7:0]        w_byte_data;

`ifdef UART_WORD_TX_CKSUM_EN
    logic [7:0] w_cksum;
    assign w_cksum = data_i[7:0] ^ data_i[15:8] ^ data_i[23:16] ^ data_i[31:24];
    assign w_frame = {w_cksum, data_i};
`else
    assign w_frame = data_i;
`endif

    // Idle only once every byte has been handed over and the serializer has
    // finished the final stop bit.
    assign w_ready = (r_left == '0) && w_idle;
    assign ready_o = w_ready;
    assign busy_o  = !w_ready;

    // The first byte goes straight from data_i so the start bit begins on
    // the edge right after the accept; later bytes come from the latch.
    assign w_byte_valid = w_ready ? valid_i     : (r_left != '0);
    assign w_byte_data  = w_ready ? data_i[7:0] : r_shift[7:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_shift <= '0;
            r_left  <= '0;
        end else if (w_ready && valid_i) begin
            r_shift <= w_frame >> 8;
            r_left  <= LeftW'(NFrames - 1);
        end else if ((r_left != '0) && w_byte_ready) begin
            r_shift <= r_shift >> 8;
            r_left  <= r_left - 1'b1;
        end
    end

    uart_tx_byte #(
        .Div (Div)
    ) u_tx_byte (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (w_byte_data),
        .valid_i (w_byte_valid),
        .ready_o (w_byte_ready),
        .idle_o  (w_idle),
        .tx_o    (tx_o)
    );

endmodule

// File: tb/tb_uart_word_tx.sv
module tb_uart_word_tx;

    localparam int DivA = 280;
    localparam int DivB = 104;
`ifdef UART_WORD_TX_CKSUM_EN
    localparam int NF = 5;
`else
    localparam int NF = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        sel;
    logic [31:0] data;

    logic valid_a, ready_a, busy_a, tx_a;
    logic valid_b, ready_b, busy_b, tx_b;
    logic w_tx, w_ready, w_busy;

    assign valid_a = valid & ~sel;
    assign valid_b = valid & sel;
    assign w_tx    = sel ? tx_b    : tx_a;
    assign w_ready = sel ? ready_b : ready_a;
    assign w_busy  = sel ? busy_b  : busy_a;

    always #5 clk = ~clk;

    uart_word_tx dut_a (
        .clk_i   (clk),
        .rst_i   (rst),
        .data_i  (data),
        .valid_i (valid_a),
        .ready_o (ready_a),
        .busy_o  (busy_a),
        .tx_o    (tx_a)
    );

    uart_word_tx #(
        .ClkFreq (12000000)
    ) dut_b (
        .clk_i   (clk),
        .rst_i   (rst),
        .data_i  (data),
        .valid_i (valid_b),
        .ready_o (ready_b),
        .busy_o  (busy_b),
        .tx_o    (tx_b)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic [39:0] bytes_exp;   // {cksum, b3, b2, b1, b0}, b0 sent first
        bit          hold;        // keep valid high into the next word
        bit          scramble;    // randomise data_i while busy
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Starts at a negedge with the DUT idle; ends at the negedge where ready
    // must be back, which is exactly NF*10*div cycles after the accept.
    task automatic run_word(input vec_t v, input int div, input string name);
        int         bad;
        int         bad_rdy;
        logic       exp_bit;
        logic [7:0] byt;
        data  = v.data;
        valid = 1'b1;
        @(negedge clk);
        if (!v.hold) valid = 1'b0;
        bad_rdy = 0;
        for (int f = 0; f < NF; f++) begin
            byt = v.bytes_exp[8*f +: 8];
            for (int b = 0; b < 10; b++) begin
                if (b == 0)      exp_bit = 1'b0;
                else if (b == 9) exp_bit = 1'b1;
                else             exp_bit = byt[b-1];
                bad = 0;
                for (int c = 0; c < div; c++) begin
                    if (w_tx !== exp_bit) bad++;
                    if (w_ready !== 1'b0 || w_busy !== 1'b1) bad_rdy++;
                    if (v.scramble) data = $urandom;
                    @(negedge clk);
                end
                check($sformatf("%s byte%0d bit%0d wrong_samples", name, f, b), bad, 0);
            end
        end
        check($sformatf("%s ready_busy_during_word bad_cycles", name), bad_rdy, 0);
        check($sformatf("%s {ready,busy,tx}_after_word", name), {w_ready, w_busy, w_tx}, 3'b101);
    endtask

    vec_t tab [4];
    vec_t v_a5;
    vec_t v_b;

    initial begin
        int bad_tx, bad_rdy, bad_busy;

        tab[0] = '{data: 32'h12345678, bytes_exp: 40'h08_12345678, hold: 1'b0, scramble: 1'b0};
        tab[1] = '{data: 32'hFFFFFFFF, bytes_exp: 40'h00_FFFFFFFF, hold: 1'b1, scramble: 1'b0};
        tab[2] = '{data: 32'h00000000, bytes_exp: 40'h00_00000000, hold: 1'b0, scramble: 1'b0};
        tab[3] = '{data: 32'hDEADBEEF, bytes_exp: 40'h22_DEADBEEF, hold: 1'b0, scramble: 1'b1};
        v_a5   = '{data: 32'hA5A5A5A5, bytes_exp: 40'h00_A5A5A5A5, hold: 1'b0, scramble: 1'b0};
        v_b    = '{data: 32'hDEADBEEF, bytes_exp: 40'h22_DEADBEEF, hold: 1'b0, scramble: 1'b0};

        rst   = 1'b1;
        valid = 1'b0;
        sel   = 1'b0;
        data  = '0;
        repeat (3) @(negedge clk);
        check("reset {ready,busy,tx}", {ready_a, busy_a, tx_a}, 3'b101);
        rst = 1'b0;

        bad_tx = 0; bad_rdy = 0; bad_busy = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1)    bad_tx++;
            if (ready_a !== 1'b1) bad_rdy++;
            if (busy_a !== 1'b0)  bad_busy++;
        end
        check("idle tx_not_high cycles", bad_tx, 0);
        check("idle ready_not_high cycles", bad_rdy, 0);
        check("idle busy_high cycles", bad_busy, 0);

        // Held-valid entries chain straight into the next word; the only
        // idle-high cycle between them is the one after ready returns.
        for (int i = 0; i < 4; i++) begin
            run_word(tab[i], DivA, $sformatf("vec%0d", i));
            if (!tab[i].hold) begin
                bad_tx = 0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (w_tx !== 1'b1 || w_ready !== 1'b1) bad_tx++;
                end
                check($sformatf("vec%0d gap idle bad_cycles", i), bad_tx, 0);
            end
        end

        // Reset during byte 1's first data bit (0x56 bit0 = 0, line low).
        data  = 32'h12345678;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (11 * DivA + 120) @(negedge clk);
        check("pre-reset {busy,tx}", {w_busy, w_tx}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        check("mid-frame reset {ready,busy,tx}", {w_ready, w_busy, w_tx}, 3'b101);
        rst = 1'b0;
        bad_tx = 0;
        for (int k = 0; k < 3 * DivA; k++) begin
            @(negedge clk);
            if (w_tx !== 1'b1 || w_ready !== 1'b1) bad_tx++;
        end
        check("post-reset idle bad_cycles", bad_tx, 0);
        run_word(v_a5, DivA, "after_reset");

        // 12 MHz instance: 104 cycles per bit.
        sel = 1'b1;
        @(negedge clk);
        check("div104 idle {ready,busy,tx}", {w_ready, w_busy, w_tx}, 3'b101);
        run_word(v_b, DivB, "div104");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
